// File: rtl/ppb_pkg.sv
// Shared types and constants for the CPU clock / programming controller.
package ppb_pkg;

  localparam int unsigned BusWidth  = 8;
  localparam int unsigned SyncDepth = 2;

  typedef enum logic [2:0] {
    StHalt,
    StAuto,
    StProgEnter,
    StProgIdle,
    StProgWrite,
    StProgExit
  } state_e;

endpackage

// File: rtl/btn_sync.sv
// Button conditioner: 2-FF synchronizer, optional debounce, registered rising-edge pulse.
// Debounce is built only when CLK_PROG_CTRL_DEBOUNCE_EN is defined (DebounceCycles >= 1).
module btn_sync
  import ppb_pkg::*;
#(
  parameter int unsigned DebounceCycles = 16,
  parameter bit          SyncOnly       = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic level_o,
  output logic pulse_o
);

  logic [SyncDepth-1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[SyncDepth-2:0], din_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level_o = sync_q[SyncDepth-1];

  if (SyncOnly) begin : g_sync_only
    assign pulse_o = 1'b0;
  end else begin : g_edge
    logic filt;

`ifdef CLK_PROG_CTRL_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DebounceCycles + 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            stable_d, stable_q;

    // A new level is adopted only after DebounceCycles consecutive differing samples.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (level_o != stable_q) begin
        if (cnt_q == CntW'(DebounceCycles - 1)) begin
          stable_d = level_o;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign filt = stable_q;
`else
    assign filt = level_o;
`endif

    logic prev_d, prev_q, pulse_d, pulse_q;

    always_comb begin
      prev_d  = filt;
      pulse_d = filt & ~prev_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        prev_q  <= prev_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_o = pulse_q;
  end

endmodule

// File: rtl/clk_prog_ctrl.sv
// CPU clock-enable generator (halt/step/free-run) with a memory programming mode.
// Optional button debounce: define CLK_PROG_CTRL_DEBOUNCE_EN.
module clk_prog_ctrl
  import ppb_pkg::*;
#(
  parameter int unsigned AUTO_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_auto_en,
  input  logic                clk_step,
  input  logic                programming_en,
  input  logic                prog_commit,
  input  logic [BusWidth-1:0] prog_addr,
  input  logic [BusWidth-1:0] prog_data,
  input  logic [BusWidth-1:0] cpu_addr,
  input  logic [BusWidth-1:0] cpu_data,
  input  logic                cpu_we,
  output logic                cpu_clk_en,
  output logic                cpu_reset,
  output logic [BusWidth-1:0] mem_addr,
  output logic [BusWidth-1:0] mem_data,
  output logic                mem_we,
  output logic                prog_busy,
  output logic [BusWidth-1:0] prog_count
);

  localparam logic [BusWidth-1:0] DivLast = BusWidth'(AUTO_DIV - 1);

  logic auto_s, prog_en_s, step_p, commit_p;
  logic unused_auto_p, unused_prog_en_p, unused_step_lvl, unused_commit_lvl;

  btn_sync #(.DebounceCycles(DEBOUNCE_CYCLES), .SyncOnly(1'b1)) u_sync_auto (
    .clk_i   (clk),
    .reset_i (reset),
    .din_i   (clk_auto_en),
    .level_o (auto_s),
    .pulse_o (unused_auto_p)
  );

  btn_sync #(.DebounceCycles(DEBOUNCE_CYCLES), .SyncOnly(1'b1)) u_sync_prog_en (
    .clk_i   (clk),
    .reset_i (reset),
    .din_i   (programming_en),
    .level_o (prog_en_s),
    .pulse_o (unused_prog_en_p)
  );

  btn_sync #(.DebounceCycles(DEBOUNCE_CYCLES), .SyncOnly(1'b0)) u_sync_step (
    .clk_i   (clk),
    .reset_i (reset),
    .din_i   (clk_step),
    .level_o (unused_step_lvl),
    .pulse_o (step_p)
  );

  btn_sync #(.DebounceCycles(DEBOUNCE_CYCLES), .SyncOnly(1'b0)) u_sync_commit (
    .clk_i   (clk),
    .reset_i (reset),
    .din_i   (prog_commit),
    .level_o (unused_commit_lvl),
    .pulse_o (commit_p)
  );

  state_e              state_d, state_q;
  logic [BusWidth-1:0] div_d, div_q;
  logic [BusWidth-1:0] count_d, count_q;
  logic [BusWidth-1:0] paddr_d, paddr_q;
  logic [BusWidth-1:0] pdata_d, pdata_q;
  logic                clk_en;

  // Pulses arriving in a state that does not consume them are simply ignored.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    count_d = count_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    clk_en  = 1'b0;
    case (state_q)
      StHalt: begin
        clk_en = step_p;
        if (prog_en_s) begin
          state_d = StProgEnter;
        end else if (auto_s) begin
          state_d = StAuto;
        end
      end
      StAuto: begin
        clk_en = (div_q == DivLast);
        div_d  = clk_en ? '0 : div_q + 1'b1;
        if (prog_en_s) begin
          state_d = StProgEnter;
          div_d   = '0;
        end else if (!auto_s) begin
          state_d = StHalt;
          div_d   = '0;
        end
      end
      StProgEnter: begin
        state_d = StProgIdle;
      end
      StProgIdle: begin
        if (commit_p) begin
          state_d = StProgWrite;
          paddr_d = prog_addr;
          pdata_d = prog_data;
        end else if (!prog_en_s) begin
          state_d = StProgExit;
        end
      end
      StProgWrite: begin
        count_d = count_q + 1'b1;
        state_d = prog_en_s ? StProgIdle : StProgExit;
      end
      StProgExit: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHalt;
      div_q   <= '0;
      count_q <= '0;
      paddr_q <= '0;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
    end
  end

  // Reset gates mem_we directly so an in-flight write is cut off without waiting for a clock.
  always_comb begin
    prog_busy  = (state_q == StProgEnter) || (state_q == StProgIdle) ||
                 (state_q == StProgWrite) || (state_q == StProgExit);
    cpu_reset  = reset | prog_busy;
    cpu_clk_en = clk_en;
    prog_count = count_q;
    if (prog_busy) begin
      mem_addr = paddr_q;
      mem_data = pdata_q;
      mem_we   = (state_q == StProgWrite) & ~reset;
    end else begin
      mem_addr = cpu_addr;
      mem_data = cpu_data;
      mem_we   = cpu_we & ~reset;
    end
  end

endmodule

// File: tb/tb_clk_prog_ctrl.sv
// Self-checking bench for clk_prog_ctrl: vector table for the memory mux plus directed sequences.
module tb_clk_prog_ctrl;

`ifdef CLK_PROG_CTRL_DEBOUNCE_EN
  localparam int Db = 16;
`else
  localparam int Db = 0;
`endif
  localparam int Lat = 3 + Db;

  logic       clk, reset;
  logic       clk_auto_en, clk_step, programming_en, prog_commit;
  logic [7:0] prog_addr, prog_data, cpu_addr, cpu_data;
  logic       cpu_we;
  logic       cpu_clk_en, cpu_reset, mem_we, prog_busy;
  logic [7:0] mem_addr, mem_data, prog_count;

  clk_prog_ctrl #(.AUTO_DIV(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_auto_en    (clk_auto_en),
    .clk_step       (clk_step),
    .programming_en (programming_en),
    .prog_commit    (prog_commit),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .cpu_we         (cpu_we),
    .cpu_clk_en     (cpu_clk_en),
    .cpu_reset      (cpu_reset),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .prog_busy      (prog_busy),
    .prog_count     (prog_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;

  int en_in_prog = 0;
  always @(negedge clk) if (prog_busy && cpu_clk_en) en_in_prog++;

  typedef struct {
    logic       prog;
    logic [7:0] a;
    logic [7:0] d;
    logic       we;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       ewe;
  } vec_t;
  vec_t vecs [8];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_table(input logic phase);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].prog == phase) begin
        @(negedge clk);
        cpu_addr = vecs[i].a;
        cpu_data = vecs[i].d;
        cpu_we   = vecs[i].we;
        #1;
        check($sformatf("tbl%0d_we", i), mem_we, vecs[i].ewe);
        if (!phase) begin
          check($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].ea);
          check($sformatf("tbl%0d_data", i), mem_data, vecs[i].ed);
        end
      end
    end
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic enter_prog();
    @(negedge clk);
    programming_en = 1'b1;
    for (int j = 0; j < 10 && !prog_busy; j++) @(negedge clk);
    check("prog_enter_busy", prog_busy, 1);
    check("prog_enter_cpu_reset", cpu_reset, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_commit(input logic [7:0] a, input logic [7:0] d);
    int wc, idx;
    logic [7:0] ga, gd;
    wc = 0; idx = -1; ga = '0; gd = '0;
    @(negedge clk);
    prog_addr = a; prog_data = d; prog_commit = 1'b1;
    for (int j = 1; j <= Lat + 4; j++) begin
      @(negedge clk);
      if (mem_we) begin
        wc++;
        if (idx < 0) begin idx = j; ga = mem_addr; gd = mem_data; end
      end
    end
    prog_commit = 1'b0;
    check("commit_we_cycles", wc, 1);
    check("commit_latency", idx, Lat + 1);
    check("commit_addr", ga, a);
    check("commit_data", gd, d);
    repeat (6 + Db) @(negedge clk);
  endtask

  int hi, idx, pulses, prev, bad, first_en;
  logic rst_ok;
  logic [31:0] we_seen, busy_seen, rst_seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h20] <= 8'h77;

    vecs[0] = '{1'b0, 8'h40, 8'h11, 1'b1, 8'h40, 8'h11, 1'b1};
    vecs[1] = '{1'b0, 8'h41, 8'hFF, 1'b0, 8'h41, 8'hFF, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'h5A, 1'b1, 8'hFF, 8'h5A, 1'b1};
    vecs[4] = '{1'b1, 8'h20, 8'hEE, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'h20, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 8'h21, 8'h13, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'h20, 8'hC3, 1'b1, 8'h00, 8'h00, 1'b0};

    reset = 1'b1;
    clk_auto_en = 1'b0; clk_step = 1'b0; programming_en = 1'b0; prog_commit = 1'b0;
    prog_addr = '0; prog_data = '0; cpu_addr = '0; cpu_data = '0; cpu_we = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_clk_en", cpu_clk_en, 0);
    check("rst_busy", prog_busy, 0);
    check("rst_count", prog_count, 0);
    check("rst_mem_we", mem_we, 0);
    cpu_we = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cpu_reset", cpu_reset, 0);

    // Single-step: one pulse per press, Lat cycles after the pin edge
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      clk_step = 1'b1;
      hi = 0; idx = -1;
      for (int j = 1; j <= Lat + 6; j++) begin
        @(negedge clk);
        if (cpu_clk_en) begin hi++; if (idx < 0) idx = j; end
        if (j == Lat + 4) clk_step = 1'b0;
      end
      check($sformatf("step%0d_latency", s), idx, Lat);
      check($sformatf("step%0d_pulses", s), hi, 1);
      repeat (14 + Db) @(negedge clk);
    end

    // Free-run: 40 cycles, pulse every 4th cycle
    @(negedge clk);
    clk_auto_en = 1'b1;
    pulses = 0; prev = -1; bad = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (cpu_clk_en) begin
        pulses++;
        if (prev >= 0 && (j - prev) != 4) bad++;
        prev = j;
      end
    end
    check("auto_pulse_count_9_to_11", (pulses >= 9 && pulses <= 11), 1);
    check("auto_pulse_spacing_errs", bad, 0);
    clk_auto_en = 1'b0;
    repeat (4) @(negedge clk);
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (cpu_clk_en) pulses++;
    end
    check("halt_after_auto_pulses", pulses, 0);

    run_table(1'b0);

    enter_prog();
    run_table(1'b1);
    do_commit(8'h10, 8'hA5);
    do_commit(8'h11, 8'h3C);
    check("prog_count_2", prog_count, 2);
    check("mem_10", mem[8'h10], 8'hA5);
    check("mem_11", mem[8'h11], 8'h3C);
    check("mem_20_untouched", mem[8'h20], 8'h77);

    // programming_en drops during the write; clk_auto_en already high
    clk_auto_en = 1'b1;
    repeat (6) @(negedge clk);
    check("auto_ignored_in_prog", prog_busy, 1);
    @(negedge clk);
    prog_addr = 8'h12; prog_data = 8'h5E; prog_commit = 1'b1;
    we_seen = '0; busy_seen = '0; rst_seen = '0; first_en = -1;
    for (int j = 1; j <= Lat + 8; j++) begin
      @(negedge clk);
      we_seen[j] = mem_we;
      busy_seen[j] = prog_busy;
      rst_seen[j] = cpu_reset;
      if (cpu_clk_en && first_en < 0) first_en = j;
      if (j == Lat - 1) programming_en = 1'b0;
      if (j == Lat + 4) prog_commit = 1'b0;
    end
    rst_ok = 1'b1;
    for (int j = 1; j <= Lat + 2; j++) if (!rst_seen[j]) rst_ok = 1'b0;
    check("drop_write_we", we_seen[Lat + 1], 1);
    check("drop_exit_we", we_seen[Lat + 2], 0);
    check("drop_exit_busy", busy_seen[Lat + 2], 1);
    check("drop_cpu_reset_held", rst_ok, 1);
    check("drop_halt_cpu_reset", rst_seen[Lat + 3], 0);
    check("drop_halt_busy", busy_seen[Lat + 3], 0);
    check("drop_first_auto_pulse", first_en, Lat + 7);
    check("drop_prog_count_3", prog_count, 3);
    check("mem_12", mem[8'h12], 8'h5E);
    clk_auto_en = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset in the middle of a write
    enter_prog();
    @(negedge clk);
    prog_addr = 8'h30; prog_data = 8'h99; prog_commit = 1'b1;
    for (int j = 1; j <= Lat + 1; j++) @(negedge clk);
    check("pre_reset_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    check("reset_abort_we", mem_we, 0);
    check("reset_abort_busy", prog_busy, 0);
    check("reset_abort_cpu_reset", cpu_reset, 1);
    check("reset_abort_count", prog_count, 0);
    prog_commit = 1'b0; programming_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("after_abort_cpu_reset", cpu_reset, 0);
    check("mem_30_not_written", mem[8'h30], 8'h00);

`ifdef CLK_PROG_CTRL_DEBOUNCE_EN
    @(negedge clk);
    clk_step = 1'b1;
    repeat (5) @(negedge clk);
    clk_step = 1'b0;
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (cpu_clk_en) pulses++;
    end
    check("glitch_no_pulse", pulses, 0);
    clk_step = 1'b1;
    pulses = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (cpu_clk_en) pulses++;
      if (j == 19) clk_step = 1'b0;
    end
    check("press_one_pulse", pulses, 1);
`endif

    check("no_clk_en_in_prog", en_in_prog, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_prog_ctrl.md
CLK_PROG_CTRL -- requirements
Module: clk_prog_ctrl

Interface
REQ-001 Parameter AUTO_DIV, default 4, CPU clock-enable period in clk cycles in auto mode (legal range 1..255).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, stable cycles needed before a button level is accepted (used only with the debounce feature).
REQ-003 Port clk, input, 1, system clock; the block uses one clock only.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port clk_auto_en, input, 1, raw async level: 1 = free-run, 0 = single-step.
REQ-006 Port clk_step, input, 1, raw async step button; a rising edge requests one CPU cycle.
REQ-007 Port programming_en, input, 1, raw async level: 1 = programming mode requested.
REQ-008 Port prog_commit, input, 1, raw async button; a rising edge writes prog_addr/prog_data to memory.
REQ-009 Port prog_addr, input, 8, programming address.
REQ-010 Port prog_data, input, 8, programming data.
REQ-011 Port cpu_addr, input, 8, CPU address bus.
REQ-012 Port cpu_data, input, 8, CPU write data.
REQ-013 Port cpu_we, input, 1, CPU memory write enable.
REQ-014 Port cpu_clk_en, output, 1, one-cycle CPU advance pulse.
REQ-015 Port cpu_reset, output, 1, holds the CPU in reset.
REQ-016 Port mem_addr, output, 8, muxed memory address.
REQ-017 Port mem_data, output, 8, muxed memory write data.
REQ-018 Port mem_we, output, 1, muxed memory write enable.
REQ-019 Port prog_busy, output, 1, high while in a PROG_* state.
REQ-020 Port prog_count, output, 8, number of committed programming writes; wraps modulo 256.

Function
REQ-021 All async inputs shall pass a 2-FF synchronizer; the step/commit edge detectors shall produce one-cycle pulses, giving 3 cycles of latency from pin to pulse.
REQ-022 The FSM shall have the states HALT, AUTO, PROG_ENTER, PROG_IDLE, PROG_WRITE, PROG_EXIT.
REQ-023 HALT: cpu_clk_en shall equal the step pulse; go to AUTO when synced clk_auto_en=1.
REQ-024 AUTO: a divider shall count 0..AUTO_DIV-1 and cpu_clk_en shall pulse when the count is AUTO_DIV-1; go to HALT when clk_auto_en=0, clearing the divider.
REQ-025 Synced programming_en=1 shall take priority over all other transitions: from HALT/AUTO go to PROG_ENTER, and cpu_clk_en shall be 0 in every PROG_* state.
REQ-026 PROG_ENTER shall assert cpu_reset for exactly 1 cycle, then go to PROG_IDLE.
REQ-027 PROG_IDLE: a commit pulse shall go to PROG_WRITE; programming_en=0 shall go to PROG_EXIT.
REQ-028 PROG_WRITE shall last exactly 1 cycle, assert mem_we=1 with mem_addr=prog_addr and mem_data=prog_data (registered at the commit pulse), increment prog_count, and return to PROG_IDLE.
REQ-029 If programming_en drops while in PROG_WRITE, the write shall complete and the FSM shall then go to PROG_EXIT.
REQ-030 PROG_EXIT shall hold cpu_reset for 1 cycle, then go to HALT regardless of clk_auto_en; AUTO is re-entered on the following cycle if clk_auto_en=1.
REQ-031 cpu_reset shall be high in all PROG_* states, so the CPU restarts at PC=0.
REQ-032 Outside PROG_* states, mem_addr/mem_data/mem_we shall be combinational pass-throughs of cpu_addr/cpu_data/cpu_we.
REQ-033 In PROG_* states other than PROG_WRITE, mem_we shall be 0; a CPU write shall never reach memory there.
REQ-034 Step or commit pulses that arrive in a state that does not consume them shall be dropped, not queued.

Reset
REQ-035 Reset shall force state HALT, divider 0, prog_count 0, synchronizers 0, cpu_clk_en 0, cpu_reset 1 (while reset is asserted), and prog_busy 0.
REQ-036 Reset asserted mid-PROG_WRITE shall abort the write, with mem_we=0 immediately (async).

Configuration
REQ-037 With CLK_PROG_CTRL_DEBOUNCE_EN defined, clk_step and prog_commit shall be accepted only after holding a new synced level for DEBOUNCE_CYCLES consecutive cycles before edge detection, adding DEBOUNCE_CYCLES cycles of latency.
REQ-038 Without CLK_PROG_CTRL_DEBOUNCE_EN, edge detection shall act directly on the synced signals, the debounce logic shall be absent, and DEBOUNCE_CYCLES shall be ignored.

Structure
REQ-039 The state enum, the 8-bit bus width constant and the synchronizer depth (2) shall live in the shared package ppb_pkg.
REQ-040 One sub-module, btn_sync, shall contain the synchronizer, the optional debounce and the rising-edge detect; it shall be instantiated for clk_step and prog_commit, and its sync stage alone shall be reused for clk_auto_en and programming_en.

Verification
REQ-041 Auto mode, AUTO_DIV=4, clk_auto_en=1 for 40 cycles -> cpu_clk_en pulses every 4th cycle, 10 pulses (±1 for entry latency).
REQ-042 Step mode, 3 step edges 20 cycles apart -> exactly 3 single-cycle cpu_clk_en pulses, each 3 cycles after its edge (no debounce).
REQ-043 Programming: programming_en=1, then commit with addr=0x10 data=0xA5, then addr=0x11 data=0x3C -> two 1-cycle mem_we writes with matching values, prog_count=2, cpu_clk_en=0 throughout.
REQ-044 cpu_we=1 held with cpu_addr=0x20 during PROG_IDLE -> mem_we stays 0 and memory at 0x20 is unchanged.
REQ-045 programming_en drops in the same cycle as PROG_WRITE -> the write completes, then PROG_EXIT, then HALT; cpu_reset is high from PROG_ENTER through PROG_EXIT inclusive.
REQ-046 With CLK_PROG_CTRL_DEBOUNCE_EN defined, a step glitch of 5 cycles with DEBOUNCE_CYCLES=16 -> no pulse; a 20-cycle press -> exactly one pulse.
